// File: rtl/controle_jogo_pkg.sv
// Shared types and constants for the naval-battle game controller.
package controle_jogo_pkg;

    typedef enum logic [2:0] {
        StDesligado,
        StPreparacao,
        StEspera,
        StConsulta,
        StAvalia,
        StFim
    } estado_e;

    localparam int unsigned TamTabuleiro      = 5;
    localparam int unsigned VidaInicialPadrao = 5;
    localparam int unsigned AlvosTotalPadrao  = 6;

    // Linear cell index, row-major over the 5x5 board.
    function automatic logic [4:0] indice_celula(input logic [2:0] lin, input logic [2:0] col);
        return 5'(int'(lin) * int'(TamTabuleiro) + int'(col));
    endfunction

endpackage

// File: rtl/controle_jogo_if.sv
// Map-ROM port: address/enable from the controller, ship bit back one cycle later.
interface controle_jogo_if;
    logic       rom_en;
    logic [7:0] rom_addr;
    logic       rom_dado;

    modport master (output rom_en, output rom_addr, input rom_dado);
    modport slave  (input rom_en, input rom_addr, output rom_dado);
endinterface

// File: rtl/controle_jogo_detector_borda.sv
// Rising-edge detector for an already synchronised, debounced button level.
module detector_borda (
    input  logic clock,
    input  logic reset_n,
    input  logic sinal_i,
    output logic borda_o
);

    logic anterior_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            anterior_q <= 1'b0;
        end else begin
            anterior_q <= sinal_i;
        end
    end

    assign borda_o = sinal_i & ~anterior_q;

endmodule

// File: rtl/controle_jogo.sv
// Game controller: power/prep/attack flow, shot validation, ROM lookup and scoring.
module controle_jogo
    import controle_jogo_pkg::*;
#(
    parameter int unsigned VIDA_INICIAL = VidaInicialPadrao,
    parameter int unsigned ALVOS_TOTAL  = AlvosTotalPadrao
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            btn_liga,
    input  logic            btn_confirma,
    input  logic [2:0]      mapa_sel,
    input  logic [2:0]      col_sw,
    input  logic [2:0]      lin_sw,
    controle_jogo_if.master rom,
    output logic            ATAQUE,
    output logic            PREPARACAO,
    output logic            DESLIGADO,
    output logic [2:0]      coordColuna,
    output logic [2:0]      coordLinha,
    output logic [2:0]      mapa,
    output logic [2:0]      vida,
    output logic            acerto,
    output logic            erro,
    output logic            vitoria,
    output logic            derrota
);

    localparam logic [2:0] Limite = 3'(TamTabuleiro);

    logic liga, confirma;

    detector_borda u_borda_liga (
        .clock   (clock),
        .reset_n (reset_n),
        .sinal_i (btn_liga),
        .borda_o (liga)
    );

    detector_borda u_borda_confirma (
        .clock   (clock),
        .reset_n (reset_n),
        .sinal_i (btn_confirma),
        .borda_o (confirma)
    );

    estado_e     estado_q, estado_d;
    logic        ataque_q, ataque_d, preparacao_q, preparacao_d, desligado_q, desligado_d;
    logic [2:0]  col_q, col_d, lin_q, lin_d, mapa_q, mapa_d, vida_q, vida_d;
    logic [4:0]  acertos_q, acertos_d;
    logic [24:0] tiros_q, tiros_d;
    logic        rom_en_q, rom_en_d;
    logic [7:0]  rom_addr_q, rom_addr_d;
    logic        acerto_q, acerto_d, erro_q, erro_d;
    logic        vitoria_q, vitoria_d, derrota_q, derrota_d;

    logic        celula_valida;
    logic [4:0]  celula_sw, celula_atual;

    always_comb begin
        celula_valida = (col_sw < Limite) && (lin_sw < Limite);
        celula_sw     = celula_valida ? indice_celula(lin_sw, col_sw) : 5'd0;
        celula_atual  = indice_celula(lin_q, col_q);

        estado_d   = estado_q;
        col_d      = col_q;
        lin_d      = lin_q;
        mapa_d     = mapa_q;
        vida_d     = vida_q;
        acertos_d  = acertos_q;
        tiros_d    = tiros_q;
        rom_en_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        acerto_d   = 1'b0;
        erro_d     = 1'b0;
        vitoria_d  = vitoria_q;
        derrota_d  = derrota_q;

        unique case (estado_q)
            StDesligado: begin
                if (liga) estado_d = StPreparacao;
            end
            StPreparacao: begin
                mapa_d = mapa_sel;
                if (confirma) begin
                    vida_d    = 3'(VIDA_INICIAL);
                    acertos_d = '0;
                    tiros_d   = '0;
                    estado_d  = StEspera;
                end
            end
            StEspera: begin
                col_d = col_sw;
                lin_d = lin_sw;
                if (confirma && celula_valida && !tiros_q[celula_sw]) begin
                    rom_en_d   = 1'b1;
                    rom_addr_d = {mapa_q, celula_sw};
                    estado_d   = StConsulta;
                end
            end
            StConsulta: begin
                estado_d = StAvalia;
            end
            StAvalia: begin
                tiros_d[celula_atual] = 1'b1;
                estado_d = StEspera;
                if (rom.rom_dado) begin
                    acertos_d = acertos_q + 5'd1;
                    acerto_d  = 1'b1;
                    if (acertos_d >= 5'(ALVOS_TOTAL)) begin
                        vitoria_d = 1'b1;
                        estado_d  = StFim;
                    end
                end else begin
                    vida_d = (vida_q == 3'd0) ? 3'd0 : vida_q - 3'd1;
                    erro_d = 1'b1;
                    if (vida_d == 3'd0) begin
                        derrota_d = 1'b1;
                        estado_d  = StFim;
                    end
                end
            end
            StFim: begin
                if (confirma) begin
                    vitoria_d = 1'b0;
                    derrota_d = 1'b0;
                    estado_d  = StPreparacao;
                end
            end
            default: estado_d = StDesligado;
        endcase

        // Power-off wins over everything, including an in-flight shot.
        if (liga && estado_q != StDesligado) begin
            estado_d   = StDesligado;
            col_d      = '0;
            lin_d      = '0;
            mapa_d     = '0;
            vida_d     = '0;
            acertos_d  = '0;
            tiros_d    = '0;
            rom_en_d   = 1'b0;
            rom_addr_d = '0;
            acerto_d   = 1'b0;
            erro_d     = 1'b0;
            vitoria_d  = 1'b0;
            derrota_d  = 1'b0;
        end

        desligado_d  = (estado_d == StDesligado);
        preparacao_d = (estado_d == StPreparacao);
        ataque_d     = !desligado_d && !preparacao_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q     <= StDesligado;
            ataque_q     <= 1'b0;
            preparacao_q <= 1'b0;
            desligado_q  <= 1'b1;
            col_q        <= '0;
            lin_q        <= '0;
            mapa_q       <= '0;
            vida_q       <= '0;
            acertos_q    <= '0;
            tiros_q      <= '0;
            rom_en_q     <= 1'b0;
            rom_addr_q   <= '0;
            acerto_q     <= 1'b0;
            erro_q       <= 1'b0;
            vitoria_q    <= 1'b0;
            derrota_q    <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            ataque_q     <= ataque_d;
            preparacao_q <= preparacao_d;
            desligado_q  <= desligado_d;
            col_q        <= col_d;
            lin_q        <= lin_d;
            mapa_q       <= mapa_d;
            vida_q       <= vida_d;
            acertos_q    <= acertos_d;
            tiros_q      <= tiros_d;
            rom_en_q     <= rom_en_d;
            rom_addr_q   <= rom_addr_d;
            acerto_q     <= acerto_d;
            erro_q       <= erro_d;
            vitoria_q    <= vitoria_d;
            derrota_q    <= derrota_d;
        end
    end

    assign ATAQUE       = ataque_q;
    assign PREPARACAO   = preparacao_q;
    assign DESLIGADO    = desligado_q;
    assign coordColuna  = col_q;
    assign coordLinha   = lin_q;
    assign mapa         = mapa_q;
    assign vida         = vida_q;
    assign acerto       = acerto_q;
    assign erro         = erro_q;
    assign vitoria      = vitoria_q;
    assign derrota      = derrota_q;
    assign rom.rom_en   = rom_en_q;
    assign rom.rom_addr = rom_addr_q;

endmodule

// File: doc/controle_jogo.md
CONTROLE_JOGO -- requirements
Module: controle_jogo

Interface
REQ-001 Parameter VIDA_INICIAL, default 5: lives loaded on entry to attack phase.
REQ-002 Parameter ALVOS_TOTAL, default 6: ship cells per map; hits needed for victory.
REQ-003 clock  in  1  single system clock, rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 btn_liga  in  1  power toggle, level, synchronous and debounced, active high.
REQ-006 btn_confirma  in  1  confirm, level, synchronous and debounced, active high.
REQ-007 mapa_sel  in  3  map-select switches.
REQ-008 col_sw / lin_sw  in  3 each  shot column and row switches; valid range 0..4.
REQ-009 rom_dado  in  1  ship-present bit from synchronous map ROM; valid the cycle after rom_en.
REQ-010 ATAQUE, PREPARACAO, DESLIGADO  out  1 each  game-mode flags for the display mux.
REQ-011 coordColuna, coordLinha, mapa, vida  out  3 each  display values.
REQ-012 rom_en  out  1;  rom_addr  out  8  = {mapa, lin*5+col}.
REQ-013 acerto, erro  out  1 each  one-cycle pulses per evaluated shot.
REQ-014 vitoria, derrota  out  1 each  end-of-game levels.

Function
REQ-015 Both buttons SHALL be edge-detected internally; one action per rising edge. Holding a button SHALL NOT repeat the action.
REQ-016 States: DESLIGADO, PREPARACAO, ESPERA, CONSULTA, AVALIA, FIM.
REQ-017 A btn_liga edge in DESLIGADO SHALL go to PREPARACAO. In any other state it SHALL go to DESLIGADO and clear all game registers. It wins over a simultaneous confirma edge.
REQ-018 In PREPARACAO, mapa SHALL follow mapa_sel each cycle. A confirma edge SHALL freeze mapa, load vida=VIDA_INICIAL, clear the hit counter and the 25-bit shot register, and go to ESPERA.
REQ-019 In ESPERA, coordColuna/coordLinha SHALL follow col_sw/lin_sw. They SHALL be frozen in CONSULTA and AVALIA.
REQ-020 A confirma edge in ESPERA with col or lin > 4 SHALL be ignored: stay in ESPERA, no ROM access, no pulse.
REQ-021 A confirma edge in ESPERA on an already-shot cell SHALL be ignored the same way.
REQ-022 A confirma edge on a valid new cell in cycle N SHALL enter CONSULTA at N+1 with rom_en=1 and rom_addr valid. The next state is AVALIA at N+2.
REQ-023 In AVALIA, the cell SHALL be marked shot. Then:
- rom_dado=1: acertos increments, acerto pulses in cycle N+3.
- rom_dado=0: vida decrements, erro pulses in cycle N+3.
REQ-024 From AVALIA the next state SHALL be:
- FIM with vitoria=1 if acertos reaches ALVOS_TOTAL;
- FIM with derrota=1 if vida reaches 0;
- otherwise ESPERA.
vida SHALL never wrap below 0.
REQ-025 Confirma edges during CONSULTA/AVALIA SHALL be discarded.
REQ-026 In FIM, displayed values SHALL hold. A confirma edge SHALL clear vitoria/derrota and go to PREPARACAO.
REQ-027 Mode flags SHALL be registered and mutually exclusive:
- DESLIGADO state: DESLIGADO=1;
- PREPARACAO state: PREPARACAO=1;
- ESPERA, CONSULTA, AVALIA, FIM: ATAQUE=1.
REQ-028 rom_en SHALL be high only in CONSULTA.

Reset
REQ-029 On reset_n=0, asynchronously:
- state=DESLIGADO, DESLIGADO=1, all other outputs 0;
- edge-detect history, shot register and counters cleared.
REQ-030 Reset mid-shot SHALL abort the shot with no pulse and no vida change.

Structure
REQ-031 A shared package SHALL hold the state enum, board size 5, and the VIDA_INICIAL/ALVOS_TOTAL defaults.
REQ-032 Sub-module detector_borda (rising-edge detector) SHALL be instantiated once per button. All other logic SHALL be flat.

Verification
REQ-033 Reset then liga edge: PREPARACAO=1; mapa_sel=3 plus confirma gives mapa=3, vida=5, ATAQUE=1.
REQ-034 Shot (2,1) with rom_dado=0: rom_addr=0x67 at N+1, erro at N+3, vida=4. Repeating (2,1) gives no rom_en and no pulse.
REQ-035 Six distinct hits with rom_dado=1: acerto x6, vitoria=1 in FIM. Confirma then gives PREPARACAO=1 and vitoria=0.
REQ-036 Five misses: derrota=1 with vida=0. Further confirma edges in ESPERA-like timing produce no decrement.
REQ-037 col_sw=5 plus confirma: no rom_en, state unchanged. Liga and confirma edges in the same cycle from ESPERA give DESLIGADO=1.
REQ-038 reset_n pulse low during CONSULTA: outputs return to reset values immediately, no acerto/erro pulse.
